dynamics_engine: RTL
====================

Name: dynamics_engine

Overview:
- Parametrised, time-multiplexed successor to the fixed 8-channel dynamics calculator.
- Scales each drum-voice sample by per-channel gain and global note velocity using one shared multiplier.
- Adds a stateful per-channel decay envelope that persists across frames and is re-triggered by note_on.
- Sits between the sample fetch stage and the voice mixer.

Parameters:
- NUM_CH, 8, number of voice channels (1..16)
- SAMPLE_W, 16, signed sample width
- GAIN_W, 7, unsigned gain/velocity width (0..127)
- DECAY_SHIFT, 6, envelope decrement shift per frame

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- samples_in_ready  in  1  one-cycle frame strobe; latches all inputs
- note_on  in  1  one-cycle pulse; re-arms all envelopes to 255
- velocity  in  GAIN_W  global velocity
- sample_in  in  NUM_CH*SAMPLE_W  packed signed samples, ch0 in LSBs
- gain  in  NUM_CH*GAIN_W  packed per-channel gain
- decay_type  in  NUM_CH  1 = apply envelope, 0 = bypass
- busy  out  1  frame in progress
- samples_out_ready  out  1  one-cycle pulse when all outputs are valid
- sample_out  out  NUM_CH*SAMPLE_W  packed signed results, held until the next frame completes

Behaviour:
- Reset (reset=0, async):
  - busy=0, samples_out_ready=0, sample_out all 0.
  - env[ch]=255, pending note flag cleared.
  - FSM returns to IDLE; a frame in progress is discarded.
- FSM IDLE -> MUL_A -> MUL_B -> (next channel MUL_A | DONE) -> IDLE.
- IDLE, samples_in_ready=1:
  - Latch all inputs and set busy=1.
  - If note_on is high in the same cycle, or a note is pending, set all env=255 before ch0 is computed.
- MUL_A (channel c): coeff = gain[c]*velocity (14b unsigned); prod = sample[c]*coeff (signed, 31b); scaled = prod >>> 14 (arithmetic, floor).
- MUL_B (channel c):
  - If decay_type[c]=1: out = (scaled*env[c]) >>> 8, floor.
  - Then env[c] -= max(env[c]>>DECAY_SHIFT, 1), saturating at 0.
  - If decay_type[c]=0: out = scaled and env[c] is unchanged.
- Write order and latency:
  - sample_out[c] is written at the end of MUL_B; the channel index wraps to DONE after NUM_CH-1.
  - DONE: samples_out_ready=1 for one cycle, busy=0.
  - Latency from the strobe cycle to the ready pulse is 2*NUM_CH+1 cycles (17 for NUM_CH=8).
- samples_in_ready while busy=1 is ignored; in-flight latched data is unaffected.
- note_on while busy=1 sets the pending flag, applied at the next frame start. Envelopes in the current frame are not disturbed.
- Results never exceed the SAMPLE_W range (coeff < 2^14, env ≤ 255), so no saturation is needed.
- gain=0 or velocity=0 yields 0 exactly. Negative inputs floor toward -inf.

Optional Feature:
- DYNAMICS_OVERRUN_EN defined:
  - Adds output port overrun (1b), a sticky flag set when samples_in_ready arrives while busy=1.
  - Cleared by reset or by a samples_in_ready accepted in IDLE with note_on=1.
- Undefined: no port is added and dropped strobes are silently ignored.

Decomposition:
- Package dynamics_pkg holds:
  - ENV_W=8, ENV_MAX=255, COEFF_SHIFT=14, ENV_SHIFT=8.
  - The FSM state enum (IDLE, MUL_A, MUL_B, DONE).
  - A channel-index width helper function.
- One sub-module, dynamics_env_bank:
  - Holds NUM_CH envelope registers.
  - Inputs: rearm, channel index, decrement-enable.
  - Output: env for the selected channel.

Test Plan:
- Reset mid-frame (reset low at cycle 5 after strobe) -> busy=0, all outputs 0, no ready pulse; a new frame then completes normally.
- NUM_CH=8, velocity=127, decay_type=0: ch1 1200/gain 64 -> 595; ch2 16'hC350 (-15536)/gain 64 -> -7708; ch0 gain 0 -> 0. samples_out_ready asserts exactly 17 cycles after the strobe.
- decay_type=1, 1200, gain 127, velocity 127, note_on with strobe:
  - frame 1 -> 1176 (env 255);
  - frame 2 -> 1162 (env 252);
  - envelope keeps falling and reaches 0 output eventually.
- note_on pulsed while busy -> current frame output unchanged; the next frame uses env=255 (1176).
- Strobe while busy -> ignored, exactly one ready pulse per accepted frame. With DYNAMICS_OVERRUN_EN, overrun=1 and stays sticky.

Source files
------------

// File: rtl/dynamics_pkg.sv
// dynamics_pkg: shared constants, FSM states and index-width helper for dynamics_engine
package dynamics_pkg;
  localparam int ENV_W = 8;
  localparam logic [ENV_W-1:0] ENV_MAX = 8'd255;
  localparam int COEFF_SHIFT = 14;
  localparam int ENV_SHIFT = 8;
  typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dynamics_env_bank.sv
// dynamics_env_bank: per-channel decay envelopes; rearm to full, decrement the selected channel
module dynamics_env_bank
  import dynamics_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DECAY_SHIFT = 6
)(
  input  logic clk,
  input  logic reset,
  input  logic rearm,
  input  logic dec,
  input  logic [idx_w(NUM_CH)-1:0] ch,
  output logic [ENV_W-1:0] env
);
  localparam int CW = idx_w(NUM_CH);
  logic [ENV_W-1:0] env_r [NUM_CH];
  logic [ENV_W-1:0] step;
  always_comb begin
    env = env_r[ch];
    step = (env >> DECAY_SHIFT) == '0 ? ENV_W'(1) : env >> DECAY_SHIFT;
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_env
    always_ff @(posedge clk or negedge reset)
      if (!reset) env_r[g] <= ENV_MAX;
      else if (rearm) env_r[g] <= ENV_MAX;
      else if (dec && ch == CW'(g)) env_r[g] <= env > step ? env - step : '0;
  end
endmodule

// File: rtl/dynamics_engine.sv
// dynamics_engine: time-multiplexed per-channel gain/velocity/envelope scaling on one shared multiplier.
// Define DYNAMICS_OVERRUN_EN to add a sticky overrun output for strobes dropped while busy.
module dynamics_engine
  import dynamics_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W = 7,
  parameter int DECAY_SHIFT = 6
)(
  input  logic clk,
  input  logic reset,
  input  logic samples_in_ready,
  input  logic note_on,
  input  logic [GAIN_W-1:0] velocity,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
  input  logic [NUM_CH*GAIN_W-1:0] gain,
  input  logic [NUM_CH-1:0] decay_type,
  output logic busy,
  output logic samples_out_ready,
`ifdef DYNAMICS_OVERRUN_EN
  output logic overrun,
`endif
  output logic [NUM_CH*SAMPLE_W-1:0] sample_out
);
  localparam int CW = idx_w(NUM_CH);
  localparam int AW = SAMPLE_W + 1;
  localparam int CFW = 2 * GAIN_W;
  localparam int BW = CFW + 1;
  state_t state, next;
  logic [CW-1:0] ch;
  logic signed [SAMPLE_W-1:0] sample_a [NUM_CH];
  logic signed [SAMPLE_W-1:0] out_a [NUM_CH];
  logic [GAIN_W-1:0] gain_a [NUM_CH];
  logic [GAIN_W-1:0] vel_r;
  logic [NUM_CH-1:0] decay_r;
  logic [CFW-1:0] coeff;
  logic signed [AW-1:0] mul_a, scaled;
  logic signed [BW-1:0] mul_b;
  logic signed [AW+BW-1:0] prod;
  logic [ENV_W-1:0] env;
  logic start, last, pending, rearm, dec;
  always_comb begin
    start = state == IDLE && samples_in_ready;
    last = ch == CW'(NUM_CH - 1);
    rearm = start && (note_on || pending);
    dec = state == MUL_B && decay_r[ch];
    busy = state == MUL_A || state == MUL_B;
    samples_out_ready = state == DONE;
    next = state == IDLE ? (samples_in_ready ? MUL_A : IDLE) :
           state == MUL_A ? MUL_B :
           state == MUL_B ? (last ? DONE : MUL_A) : IDLE;
    coeff = CFW'(gain_a[ch]) * CFW'(vel_r);
    // MUL_A scales the sample by gain*velocity; MUL_B reuses the multiplier for the envelope
    mul_a = state == MUL_A ? AW'(sample_a[ch]) : scaled;
    mul_b = state == MUL_A ? BW'({1'b0, coeff}) : BW'({1'b0, env});
    prod = mul_a * mul_b;
  end
  always_ff @(posedge clk)
    if (start) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sample_a[i] <= sample_in[i*SAMPLE_W +: SAMPLE_W];
        gain_a[i] <= gain[i*GAIN_W +: GAIN_W];
      end
      vel_r <= velocity;
      decay_r <= decay_type;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ch <= '0;
      scaled <= '0;
      pending <= 1'b0;
      out_a <= '{default: '0};
    end else begin
      state <= next;
      pending <= start ? 1'b0 : pending | note_on;
      if (state == MUL_B) ch <= last ? '0 : ch + CW'(1);
      if (state == MUL_A) scaled <= AW'(prod >>> COEFF_SHIFT);
      if (state == MUL_B) out_a[ch] <= decay_r[ch] ? SAMPLE_W'(prod >>> ENV_SHIFT) : SAMPLE_W'(scaled);
    end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign sample_out[g*SAMPLE_W +: SAMPLE_W] = out_a[g];
  end
`ifdef DYNAMICS_OVERRUN_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) overrun <= 1'b0;
    else if (samples_in_ready && busy) overrun <= 1'b1;
    else if (start && note_on) overrun <= 1'b0;
`endif
  dynamics_env_bank #(.NUM_CH(NUM_CH), .DECAY_SHIFT(DECAY_SHIFT)) u_env (
    .clk(clk),
    .reset(reset),
    .rearm(rearm),
    .dec(dec),
    .ch(ch),
    .env(env)
  );
endmodule
